mux_n_1_reg: RTL and testbench

//   Parametrised N:1 operand selector with a registered, valid/ready output stage.

---
 rtl/mux_n_1_reg.sv | 109 ++++++++++
 tb/tb_mux_n_1_reg.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_1_reg.sv
// N:1 operand selector with fixed or round-robin grant and a single-entry
// registered valid/ready output stage that holds data under back-pressure.
module mux_n_1_reg #(
  parameter int WIDTH_OP = 5,
  parameter int N_CH     = 4,
  localparam int SEL_W   = $clog2(N_CH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_CH*WIDTH_OP-1:0] i_data,
  input  logic [N_CH-1:0]          i_valid,
  output logic [N_CH-1:0]          o_ready,
  input  logic [SEL_W-1:0]         i_sel,
  input  logic                     i_mode,
  output logic [WIDTH_OP-1:0]      o_out_Mux,
  output logic [SEL_W-1:0]         o_ch,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [SEL_W-1:0]         o_rr_ptr
);

  // Handshake: an input channel k transfers on a clock edge where
  // i_valid[k] & o_ready[k]; the output transfers where o_valid & i_ready.
  // A channel that raised valid may not depend on ready to keep it.

  localparam int IW = SEL_W + 1;
  localparam logic [IW-1:0]    N_CH_I = IW'(N_CH);
  localparam logic [SEL_W-1:0] LAST   = SEL_W'(N_CH - 1);

  logic [WIDTH_OP-1:0] chan [N_CH];
  logic [SEL_W-1:0]    ptr;
  logic [SEL_W-1:0]    rr_gnt;
  logic [IW-1:0]       rr_idx;
  logic                rr_found;
  logic                sel_ok;
  logic                fix_valid;
  logic                can_acc;
  logic [SEL_W-1:0]    gnt;
  logic                gnt_vld;
  logic                xfer_in;
  logic [WIDTH_OP-1:0] gnt_data;

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      chan[k] = i_data[k*WIDTH_OP +: WIDTH_OP];
    end
  end

  // Round-robin search starting at ptr, wrapping modulo N_CH.
  always_comb begin
    rr_found = 1'b0;
    rr_gnt   = '0;
    rr_idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      rr_idx = {1'b0, ptr} + IW'(i);
      if (rr_idx >= N_CH_I) rr_idx = rr_idx - N_CH_I;
      for (int k = 0; k < N_CH; k++) begin
        if (!rr_found && rr_idx == IW'(k) && i_valid[k]) begin
          rr_found = 1'b1;
          rr_gnt   = SEL_W'(k);
        end
      end
    end
  end

  always_comb begin
    sel_ok    = ({1'b0, i_sel} < N_CH_I);
    can_acc   = !o_valid || i_ready;
    fix_valid = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (i_sel == SEL_W'(k)) fix_valid = i_valid[k];
    end
    if (i_mode) begin
      gnt     = rr_gnt;
      gnt_vld = rr_found;
    end else begin
      gnt     = i_sel;
      gnt_vld = sel_ok && fix_valid;
    end
    xfer_in  = !i_rst && can_acc && gnt_vld;
    gnt_data = '0;
    o_ready  = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt == SEL_W'(k)) gnt_data = chan[k];
      // Fixed mode offers ready on the selected channel even when it is idle.
      if (i_mode) o_ready[k] = !i_rst && can_acc && rr_found && (rr_gnt == SEL_W'(k));
      else        o_ready[k] = !i_rst && can_acc && sel_ok && (i_sel == SEL_W'(k));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid   <= 1'b0;
      o_out_Mux <= '0;
      o_ch      <= '0;
      ptr       <= '0;
    end else if (xfer_in) begin
      o_valid   <= 1'b1;
      o_out_Mux <= gnt_data;
      o_ch      <= gnt;
      if (i_mode) ptr <= (gnt == LAST) ? '0 : gnt + SEL_W'(1);
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

  assign o_rr_ptr = ptr;

endmodule

// File: tb/tb_mux_n_1_reg.sv
// Bench for mux_n_1_reg: directed scenarios plus a randomized fixed-mode stream,
// with output transfers checked against an expected queue.
module tb_mux_n_1_reg;

  logic        clk;
  logic        i_rst;
  logic [19:0] i_data;
  logic [3:0]  i_valid;
  logic [3:0]  o_ready;
  logic [1:0]  i_sel;
  logic        i_mode;
  logic [4:0]  o_out_mux;
  logic [1:0]  o_ch;
  logic        o_valid;
  logic        i_ready;
  logic [1:0]  o_rr_ptr;

  // Three-channel instance for the out-of-range select case.
  logic [14:0] d3_data;
  logic [2:0]  d3_valid;
  logic [2:0]  d3_oready;
  logic [1:0]  d3_sel;
  logic [4:0]  d3_out;
  logic [1:0]  d3_ch;
  logic        d3_ovalid;
  logic [1:0]  d3_ptr;

  int checks;
  int failures;
  logic [6:0] exp_q[$];

  mux_n_1_reg #(.WIDTH_OP(5), .N_CH(4)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .i_sel(i_sel), .i_mode(i_mode), .o_out_Mux(o_out_mux),
    .o_ch(o_ch), .o_valid(o_valid), .i_ready(i_ready), .o_rr_ptr(o_rr_ptr)
  );

  mux_n_1_reg #(.WIDTH_OP(5), .N_CH(3)) dut3 (
    .i_clk(clk), .i_rst(i_rst), .i_data(d3_data), .i_valid(d3_valid),
    .o_ready(d3_oready), .i_sel(d3_sel), .i_mode(1'b0), .o_out_Mux(d3_out),
    .o_ch(d3_ch), .o_valid(d3_ovalid), .i_ready(1'b1), .o_rr_ptr(d3_ptr)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [4:0] v);
    i_data[ch*5 +: 5] = v;
  endtask

  function automatic logic [4:0] get_ch(input int ch);
    return i_data[ch*5 +: 5];
  endfunction

  task automatic drain();
    i_valid = '0;
    i_ready = 1'b1;
    tick();
    tick();
  endtask

  // Scoreboard: every output transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (!i_rst && o_valid === 1'b1 && i_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_xfer unexpected got ch=%0d data=%h", o_ch, o_out_mux);
      end else begin
        logic [6:0] e;
        e = exp_q.pop_front();
        if ({o_ch, o_out_mux} !== e) begin
          failures++;
          $display("FAIL out_xfer got ch=%0d data=%h exp ch=%0d data=%h",
                   o_ch, o_out_mux, e[6:5], e[4:0]);
        end
      end
    end
  end

  task automatic test_reset();
    i_rst   = 1'b1;
    i_valid = 4'hF;
    i_ready = 1'b1;
    i_mode  = 1'b1;
    i_sel   = 2'd0;
    i_data  = 20'($urandom);
    @(negedge clk);
    checks++;
    if (o_ready !== 4'b0000) begin
      failures++; $display("FAIL reset_ready got %b exp 0000", o_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({o_valid, o_out_mux, o_ch, o_rr_ptr} !== 10'd0) begin
      failures++;
      $display("FAIL reset_state got v=%b d=%h ch=%0d ptr=%0d exp all zero",
               o_valid, o_out_mux, o_ch, o_rr_ptr);
    end
    tick();
    i_rst   = 1'b0;
    i_valid = '0;
    i_mode  = 1'b0;
    tick();
  endtask

  task automatic test_fixed();
    i_mode  = 1'b0;
    i_sel   = 2'd2;
    i_ready = 1'b1;
    i_data  = 20'($urandom);
    set_ch(2, 5'h15);
    i_valid = 4'b0100;
    exp_q.push_back({2'd2, 5'h15});
    @(negedge clk);
    checks++;
    if (o_ready !== 4'b0100) begin
      failures++; $display("FAIL fixed_ready got %b exp 0100", o_ready);
    end
    tick();
    i_valid = '0;
    i_sel   = 2'd1;
    @(negedge clk);
    checks++;
    if ({o_valid, o_ch, o_out_mux} !== {1'b1, 2'd2, 5'h15}) begin
      failures++;
      $display("FAIL fixed_out got v=%b ch=%0d d=%h exp v=1 ch=2 d=15", o_valid, o_ch, o_out_mux);
    end
    checks++;
    if (o_ready !== 4'b0010) begin
      failures++; $display("FAIL fixed_ready_idle got %b exp 0010", o_ready);
    end
    checks++;
    if (o_rr_ptr !== 2'd0) begin
      failures++; $display("FAIL fixed_ptr got %0d exp 0", o_rr_ptr);
    end
    drain();
  endtask

  task automatic test_round_robin();
    i_mode  = 1'b1;
    i_ready = 1'b1;
    i_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      int g;
      g = i % 4;
      i_data = 20'($urandom);
      exp_q.push_back({2'(g), get_ch(g)});
      @(negedge clk);
      checks++;
      if (o_ready !== 4'(1 << g)) begin
        failures++; $display("FAIL rr_ready step %0d got %b exp %b", i, o_ready, 4'(1 << g));
      end
      if (i > 0) begin
        checks++;
        if (o_valid !== 1'b1) begin
          failures++; $display("FAIL rr_bubble step %0d got o_valid=%b exp 1", i, o_valid);
        end
      end
      tick();
    end
    drain();
    checks++;
    if (o_rr_ptr !== 2'd1) begin
      failures++; $display("FAIL rr_ptr got %0d exp 1", o_rr_ptr);
    end
  endtask

  task automatic test_back_pressure();
    logic [4:0] a;
    logic [4:0] b;
    i_mode  = 1'b0;
    i_sel   = 2'd0;
    i_ready = 1'b1;
    a = 5'($urandom);
    set_ch(0, a);
    i_valid = 4'b0001;
    exp_q.push_back({2'd0, a});
    tick();
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_data  = 20'($urandom);
      i_valid = 4'($urandom_range(1, 15));
      i_sel   = 2'($urandom_range(0, 3));
      @(negedge clk);
      checks++;
      if ({o_valid, o_ch, o_out_mux, o_ready} !== {1'b1, 2'd0, a, 4'b0000}) begin
        failures++;
        $display("FAIL bp_hold cyc %0d got v=%b ch=%0d d=%h rdy=%b exp v=1 ch=0 d=%h rdy=0000",
                 i, o_valid, o_ch, o_out_mux, o_ready, a);
      end
      tick();
    end
    i_ready = 1'b1;
    i_sel   = 2'd1;
    i_valid = 4'b0010;
    b = 5'($urandom);
    set_ch(1, b);
    exp_q.push_back({2'd1, b});
    @(negedge clk);
    checks++;
    if (o_ready !== 4'b0010) begin
      failures++; $display("FAIL bp_release_ready got %b exp 0010", o_ready);
    end
    tick();
    i_valid = '0;
    @(negedge clk);
    checks++;
    if ({o_valid, o_ch, o_out_mux} !== {1'b1, 2'd1, b}) begin
      failures++;
      $display("FAIL bp_reload got v=%b ch=%0d d=%h exp v=1 ch=1 d=%h", o_valid, o_ch, o_out_mux, b);
    end
    drain();
  endtask

  task automatic test_skip_wrap();
    i_mode  = 1'b1;
    i_ready = 1'b1;
    i_data  = 20'($urandom);
    i_valid = 4'b0100;
    exp_q.push_back({2'd2, get_ch(2)});
    tick();
    checks++;
    if (o_rr_ptr !== 2'd3) begin
      failures++; $display("FAIL skip_ptr_setup got %0d exp 3", o_rr_ptr);
    end
    i_valid = 4'b0010;
    exp_q.push_back({2'd1, get_ch(1)});
    @(negedge clk);
    checks++;
    if (o_ready !== 4'b0010) begin
      failures++; $display("FAIL skip_ready got %b exp 0010", o_ready);
    end
    tick();
    checks++;
    if (o_rr_ptr !== 2'd2) begin
      failures++; $display("FAIL skip_ptr got %0d exp 2", o_rr_ptr);
    end
    i_valid = 4'b1000;
    exp_q.push_back({2'd3, get_ch(3)});
    tick();
    checks++;
    if (o_rr_ptr !== 2'd0) begin
      failures++; $display("FAIL wrap_ptr got %0d exp 0", o_rr_ptr);
    end
    drain();
  endtask

  task automatic test_reset_mid_op();
    i_mode  = 1'b1;
    i_ready = 1'b1;
    i_data  = 20'($urandom);
    i_valid = 4'b0100;
    exp_q.push_back({2'd2, get_ch(2)});
    tick();
    i_valid = '0;
    i_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_rr_ptr !== 2'd3) begin
      failures++; $display("FAIL mid_setup got v=%b ptr=%0d exp v=1 ptr=3", o_valid, o_rr_ptr);
    end
    i_rst   = 1'b1;
    i_valid = 4'hF;
    i_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (o_ready !== 4'b0000) begin
      failures++; $display("FAIL mid_rst_ready got %b exp 0000", o_ready);
    end
    tick();
    exp_q.delete();
    i_rst  = 1'b0;
    i_data = 20'($urandom);
    exp_q.push_back({2'd0, get_ch(0)});
    @(negedge clk);
    checks++;
    if ({o_valid, o_rr_ptr, o_ready} !== {1'b0, 2'd0, 4'b0001}) begin
      failures++;
      $display("FAIL mid_after got v=%b ptr=%0d rdy=%b exp v=0 ptr=0 rdy=0001", o_valid, o_rr_ptr, o_ready);
    end
    tick();
    drain();
  endtask

  task automatic test_back_to_back();
    logic mvalid;
    mvalid  = 1'b0;
    i_mode  = 1'b0;
    i_valid = 4'hF;
    for (int i = 0; i < 24; i++) begin
      logic acc;
      int s;
      s       = $urandom_range(0, 3);
      i_sel   = 2'(s);
      i_ready = 1'($urandom_range(0, 1));
      i_data  = 20'($urandom);
      acc     = !mvalid || i_ready;
      if (acc) exp_q.push_back({2'(s), get_ch(s)});
      @(negedge clk);
      checks++;
      if (o_ready !== (acc ? 4'(1 << s) : 4'b0000) || o_valid !== mvalid) begin
        failures++;
        $display("FAIL b2b cyc %0d got rdy=%b v=%b exp rdy=%b v=%b",
                 i, o_ready, o_valid, acc ? 4'(1 << s) : 4'b0000, mvalid);
      end
      if (acc) mvalid = 1'b1;
      tick();
    end
    drain();
  endtask

  task automatic test_out_of_range();
    d3_data  = 15'($urandom);
    d3_valid = 3'b111;
    d3_sel   = 2'd3;
    @(negedge clk);
    checks++;
    if (d3_oready !== 3'b000) begin
      failures++; $display("FAIL oor_ready got %b exp 000", d3_oready);
    end
    tick();
    checks++;
    if (d3_ovalid !== 1'b0) begin
      failures++; $display("FAIL oor_state got v=%b exp 0", d3_ovalid);
    end
    d3_sel = 2'd2;
    @(negedge clk);
    checks++;
    if (d3_oready !== 3'b100) begin
      failures++; $display("FAIL oor_inrange_ready got %b exp 100", d3_oready);
    end
    tick();
    checks++;
    if ({d3_ovalid, d3_ch, d3_out} !== {1'b1, 2'd2, d3_data[14:10]}) begin
      failures++;
      $display("FAIL oor_inrange_out got v=%b ch=%0d d=%h exp v=1 ch=2 d=%h",
               d3_ovalid, d3_ch, d3_out, d3_data[14:10]);
    end
    d3_valid = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    d3_data  = '0;
    d3_valid = '0;
    d3_sel   = '0;
    test_reset();
    test_fixed();
    test_round_robin();
    test_back_pressure();
    test_skip_wrap();
    test_reset_mid_op();
    test_back_to_back();
    test_out_of_range();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
